// File: rtl/chip_invaders_pkg.sv
// ---------------------------------------------------------------------------
// chip_invaders_pkg
// Shared types and constants for the alien formation controller.
//   COORD_W        : width of every screen coordinate (origin, scan position)
//   swarm_state_t  : formation movement state (RIGHT, LEFT, DROP, HALT)
// ---------------------------------------------------------------------------
package chip_invaders_pkg;

    localparam int unsigned COORD_W = 16;

    typedef enum logic [1:0] {
        RIGHT = 2'd0,
        LEFT  = 2'd1,
        DROP  = 2'd2,
        HALT  = 2'd3
    } swarm_state_t;

endpackage

// File: rtl/swarm_step_timer.sv
// ---------------------------------------------------------------------------
// swarm_step_timer
// Converts frame ticks into formation steps. A tick whose counter value has
// reached the effective period produces a one-cycle `step` and restarts the
// count; any other tick just increments the counter.
//
// Optional feature macro: ALIEN_SWARM_SPEEDUP_EN
//   defined   : effective period shrinks as the formation thins out
//               (<= half alive: period/2, <= quarter: period/4, last one: 0)
//   undefined : effective period is step_period unchanged
//
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   tick         : one-cycle frame pulse
//   step_period  : ticks between steps (0 = step every tick)
//   alive_count  : current number of live aliens (registered)
//   step         : combinational, high in the tick cycle that moves the swarm
// ---------------------------------------------------------------------------
module swarm_step_timer
    import chip_invaders_pkg::*;
#(
    parameter int unsigned TOTAL = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic [COORD_W-1:0] step_period,
    input  logic [7:0]         alive_count,
    output logic               step
);

    logic [COORD_W-1:0] tick_cnt_q;
    logic [COORD_W-1:0] tick_cnt_d;
    logic [COORD_W-1:0] eff_period;

`ifdef ALIEN_SWARM_SPEEDUP_EN
    // Most aggressive rule is checked first so the last alien always wins.
    always_comb begin
        if (alive_count == 8'd1) begin
            eff_period = '0;
        end else if (32'(alive_count) <= TOTAL / 4) begin
            eff_period = step_period >> 2;
        end else if (32'(alive_count) <= TOTAL / 2) begin
            eff_period = step_period >> 1;
        end else begin
            eff_period = step_period;
        end
    end
`else
    logic unused_speedup;
    assign unused_speedup = ^{alive_count, 8'(TOTAL)};
    assign eff_period     = step_period;
`endif

    assign step = tick && (tick_cnt_q >= eff_period);

    // The counter never exceeds eff_period before restarting, so +1 cannot wrap.
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        if (tick) begin
            if (step) begin
                tick_cnt_d = '0;
            end else begin
                tick_cnt_d = tick_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

endmodule

// File: rtl/alien_swarm.sv
// ---------------------------------------------------------------------------
// alien_swarm
// Moves a ROWS x COLS formation of aliens as one body: marches horizontally,
// bounces off the playfield bounds using the extents of the live columns,
// drops on every bounce, tracks per-alien alive state and raises sticky
// landed / cleared flags. Drives the per-pixel `graphics` bit for the mixer.
//
// Optional feature macro: ALIEN_SWARM_SPEEDUP_EN (step pacing speeds up as
// the formation thins; implemented in swarm_step_timer).
//
// Ports
//   clk, rst_n         : clock, asynchronous active-low reset
//   tick, step_period  : frame pulse and ticks between steps
//   kill_valid/row/col : kill request for alien (row, col)
//   scan_x, scan_y     : current video pixel
//   graphics           : combinational, pixel lies in a live alien's box
//   alive_mask         : bit r*COLS+c set while alien (r,c) is alive
//   alive_count        : number of live aliens
//   origin_x/origin_y  : top-left of cell (0,0)
//   landed, cleared    : sticky end-of-wave flags
//   state_dbg          : current movement state
//
// Handshake: kill_valid is a single-cycle strobe with no back-pressure; a
// request for a live, in-range alien is applied on the next clock edge, any
// other request (dead target, out of range, formation halted) is dropped.
// ---------------------------------------------------------------------------
module alien_swarm
    import chip_invaders_pkg::*;
#(
    parameter int unsigned ROWS     = 4,
    parameter int unsigned COLS     = 8,
    parameter int unsigned SPRITE_W = 4,
    parameter int unsigned SPRITE_H = 4,
    parameter int unsigned PITCH_X  = 8,
    parameter int unsigned PITCH_Y  = 8,
    parameter int unsigned INIT_X   = 16,
    parameter int unsigned INIT_Y   = 16,
    parameter int unsigned X_MIN    = 0,
    parameter int unsigned X_MAX    = 159,
    parameter int unsigned STEP_X   = 1,
    parameter int unsigned DROP_Y   = 4,
    parameter int unsigned Y_LIMIT  = 110
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    tick,
    input  logic [15:0]                             step_period,
    input  logic                                    kill_valid,
    input  logic [(ROWS > 1 ? $clog2(ROWS) : 1)-1:0] kill_row,
    input  logic [(COLS > 1 ? $clog2(COLS) : 1)-1:0] kill_col,
    input  logic [COORD_W-1:0]                      scan_x,
    input  logic [COORD_W-1:0]                      scan_y,
    output logic                                    graphics,
    output logic [ROWS*COLS-1:0]                    alive_mask,
    output logic [7:0]                              alive_count,
    output logic [COORD_W-1:0]                      origin_x,
    output logic [COORD_W-1:0]                      origin_y,
    output logic                                    landed,
    output logic                                    cleared,
    output swarm_state_t                            state_dbg
);

    localparam int unsigned TOTAL = ROWS * COLS;

    swarm_state_t       state_q, state_d;
    swarm_state_t       dir_next_q, dir_next_d;
    logic [COORD_W-1:0] origin_x_q, origin_x_d;
    logic [COORD_W-1:0] origin_y_q, origin_y_d;
    logic [TOTAL-1:0]   alive_mask_q, alive_mask_d;
    logic [7:0]         alive_count_q, alive_count_d;
    logic               landed_q, landed_d;
    logic               cleared_q, cleared_d;

    logic               step;

    swarm_step_timer #(
        .TOTAL(TOTAL)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .step_period(step_period),
        .alive_count(alive_count_q),
        .step       (step)
    );

    // ---------------- live extents (pre-kill, from registered mask) --------
    logic [COLS-1:0] col_live;
    logic [ROWS-1:0] row_live;
    logic [31:0]     lo_col, hi_col, low_row;
    logic [31:0]     left_edge, right_edge, bottom_edge;

    always_comb begin
        col_live = '0;
        row_live = '0;
        for (int r = 0; r < int'(ROWS); r++) begin
            for (int c = 0; c < int'(COLS); c++) begin
                if (alive_mask_q[r*COLS+c]) begin
                    col_live[c] = 1'b1;
                    row_live[r] = 1'b1;
                end
            end
        end
        // Downward scan leaves the smallest live column; upward scans leave
        // the largest live column and the bottom-most live row.
        lo_col = '0;
        for (int c = int'(COLS) - 1; c >= 0; c--) begin
            if (col_live[c]) lo_col = 32'(c);
        end
        hi_col = '0;
        for (int c = 0; c < int'(COLS); c++) begin
            if (col_live[c]) hi_col = 32'(c);
        end
        low_row = '0;
        for (int r = 0; r < int'(ROWS); r++) begin
            if (row_live[r]) low_row = 32'(r);
        end
        // 32-bit arithmetic keeps the bound checks from wrapping.
        left_edge   = 32'(origin_x_q) + lo_col * PITCH_X;
        right_edge  = 32'(origin_x_q) + hi_col * PITCH_X + SPRITE_W - 1;
        bottom_edge = 32'(origin_y_q) + low_row * PITCH_Y + SPRITE_H - 1;
    end

    // ---------------- kill decode ------------------------------------------
    logic [TOTAL-1:0] kill_sel;
    logic             kill_hit;

    always_comb begin
        kill_sel = '0;
        for (int r = 0; r < int'(ROWS); r++) begin
            for (int c = 0; c < int'(COLS); c++) begin
                if (kill_valid && int'(kill_row) == r && int'(kill_col) == c) begin
                    kill_sel[r*COLS+c] = 1'b1;
                end
            end
        end
        // Out-of-range targets match no cell; dead targets miss the mask.
        kill_hit = (state_q != HALT) && |(kill_sel & alive_mask_q);
    end

    // ---------------- movement FSM next state ------------------------------
    always_comb begin
        state_d       = state_q;
        dir_next_d    = dir_next_q;
        origin_x_d    = origin_x_q;
        origin_y_d    = origin_y_q;
        alive_mask_d  = alive_mask_q;
        alive_count_d = alive_count_q;
        landed_d      = landed_q;
        cleared_d     = cleared_q;

        if (kill_hit) begin
            alive_mask_d  = alive_mask_q & ~kill_sel;
            alive_count_d = alive_count_q - 8'd1;
        end

        if (state_q != HALT) begin
            if (alive_mask_d == '0) begin
                // Last kill ends the wave on this edge; no step is taken.
                state_d   = HALT;
                cleared_d = 1'b1;
            end else if (step) begin
                case (state_q)
                    RIGHT: begin
                        if (right_edge + STEP_X > X_MAX) begin
                            state_d    = DROP;
                            dir_next_d = LEFT;
                        end else begin
                            origin_x_d = origin_x_q + COORD_W'(STEP_X);
                        end
                    end
                    LEFT: begin
                        if (left_edge < X_MIN + STEP_X) begin
                            state_d    = DROP;
                            dir_next_d = RIGHT;
                        end else begin
                            origin_x_d = origin_x_q - COORD_W'(STEP_X);
                        end
                    end
                    DROP: begin
                        origin_y_d = origin_y_q + COORD_W'(DROP_Y);
                        if (bottom_edge + DROP_Y >= Y_LIMIT) begin
                            state_d  = HALT;
                            landed_d = 1'b1;
                        end else begin
                            state_d = dir_next_q;
                        end
                    end
                    default: state_d = state_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RIGHT;
            dir_next_q    <= RIGHT;
            origin_x_q    <= COORD_W'(INIT_X);
            origin_y_q    <= COORD_W'(INIT_Y);
            alive_mask_q  <= '1;
            alive_count_q <= 8'(TOTAL);
            landed_q      <= 1'b0;
            cleared_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            dir_next_q    <= dir_next_d;
            origin_x_q    <= origin_x_d;
            origin_y_q    <= origin_y_d;
            alive_mask_q  <= alive_mask_d;
            alive_count_q <= alive_count_d;
            landed_q      <= landed_d;
            cleared_q     <= cleared_d;
        end
    end

    // ---------------- pixel hit test ---------------------------------------
    // Offsets from the origin are compared against each column/row box; a
    // scan position left of / above the origin never hits.
    logic [31:0]      dx, dy;
    logic [COLS-1:0]  col_hit;
    logic [ROWS-1:0]  row_hit;
    logic [TOTAL-1:0] cell_hit;

    always_comb begin
        dx = 32'(scan_x) - 32'(origin_x_q);
        dy = 32'(scan_y) - 32'(origin_y_q);
        col_hit = '0;
        for (int c = 0; c < int'(COLS); c++) begin
            col_hit[c] = (scan_x >= origin_x_q) && (dx >= 32'(c) * PITCH_X) &&
                         (dx < 32'(c) * PITCH_X + SPRITE_W);
        end
        row_hit = '0;
        for (int r = 0; r < int'(ROWS); r++) begin
            row_hit[r] = (scan_y >= origin_y_q) && (dy >= 32'(r) * PITCH_Y) &&
                         (dy < 32'(r) * PITCH_Y + SPRITE_H);
        end
        cell_hit = '0;
        for (int r = 0; r < int'(ROWS); r++) begin
            for (int c = 0; c < int'(COLS); c++) begin
                cell_hit[r*COLS+c] = row_hit[r] & col_hit[c];
            end
        end
    end

    assign graphics    = |(cell_hit & alive_mask_q);
    assign alive_mask  = alive_mask_q;
    assign alive_count = alive_count_q;
    assign origin_x    = origin_x_q;
    assign origin_y    = origin_y_q;
    assign landed      = landed_q;
    assign cleared     = cleared_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_alien_swarm.sv
`timescale 1ns/1ps
module tb_alien_swarm;
    import chip_invaders_pkg::*;

    localparam int ROWS = 4, COLS = 8, SW = 4, SH = 4, PX = 8, PY = 8;
    localparam int IX = 16, IY = 16, XMIN = 0, XMAX = 159;
    localparam int STEPX = 1, DROPY = 4, YLIM = 110;
`ifdef ALIEN_SWARM_SPEEDUP_EN
    localparam int EXP_HALF = 5, EXP_QUARTER = 3;
`else
    localparam int EXP_HALF = 9, EXP_QUARTER = 9;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         tick = 1'b0;
    logic [15:0]  step_period = '0;
    logic         kill_valid = 1'b0;
    logic [1:0]   kill_row = '0;
    logic [2:0]   kill_col = '0;
    logic [15:0]  scan_x = '0, scan_y = '0;
    logic         graphics;
    logic [31:0]  alive_mask;
    logic [7:0]   alive_count;
    logic [15:0]  origin_x, origin_y;
    logic         landed, cleared;
    swarm_state_t state_dbg;

    int n_tests = 0;
    int n_fail = 0;

    // Reference model: formation as a 2-D alive array plus origin/direction.
    int m_ox, m_oy, m_dir, m_cnt, m_count;
    bit m_drop, m_halt, m_landed, m_cleared;
    bit m_alive [ROWS][COLS];

    alien_swarm dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .step_period(step_period),
        .kill_valid (kill_valid),
        .kill_row   (kill_row),
        .kill_col   (kill_col),
        .scan_x     (scan_x),
        .scan_y     (scan_y),
        .graphics   (graphics),
        .alive_mask (alive_mask),
        .alive_count(alive_count),
        .origin_x   (origin_x),
        .origin_y   (origin_y),
        .landed     (landed),
        .cleared    (cleared),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic void model_reset();
        m_ox = IX; m_oy = IY; m_dir = 1; m_cnt = 0; m_count = ROWS * COLS;
        m_drop = 0; m_halt = 0; m_landed = 0; m_cleared = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) m_alive[r][c] = 1'b1;
    endfunction

    function automatic int model_eff();
`ifdef ALIEN_SWARM_SPEEDUP_EN
        if (m_count == 1) return 0;
        if (m_count <= ROWS * COLS / 4) return int'(step_period) / 4;
        if (m_count <= ROWS * COLS / 2) return int'(step_period) / 2;
`endif
        return int'(step_period);
    endfunction

    function automatic void model_apply(bit t, bit kv, int kr, int kc);
        bit stp = 0;
        bit kill_ok;
        int lo = COLS, hi = -1, low = -1;
        int new_count;
        if (t) begin
            if (m_cnt >= model_eff()) begin stp = 1; m_cnt = 0; end
            else m_cnt++;
        end
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (m_alive[r][c]) begin
                    if (c < lo) lo = c;
                    if (c > hi) hi = c;
                    if (r > low) low = r;
                end
        kill_ok = !m_halt && kv && kr < ROWS && kc < COLS && m_alive[kr][kc];
        new_count = m_count - (kill_ok ? 1 : 0);
        if (!m_halt && new_count == 0) begin
            m_halt = 1; m_cleared = 1;
        end else if (!m_halt && stp) begin
            if (m_drop) begin
                m_oy += DROPY;
                if (m_oy + low * PY + SH - 1 >= YLIM) begin m_halt = 1; m_landed = 1; end
                else m_drop = 0;
            end else if (m_dir > 0) begin
                if (m_ox + hi * PX + SW - 1 + STEPX > XMAX) begin m_drop = 1; m_dir = -1; end
                else m_ox += STEPX;
            end else begin
                if (m_ox + lo * PX < XMIN + STEPX) begin m_drop = 1; m_dir = 1; end
                else m_ox -= STEPX;
            end
        end
        if (kill_ok) begin m_alive[kr][kc] = 1'b0; m_count = new_count; end
    endfunction

    function automatic swarm_state_t model_state();
        if (m_halt) return HALT;
        if (m_drop) return DROP;
        return (m_dir > 0) ? RIGHT : LEFT;
    endfunction

    function automatic logic [31:0] model_mask();
        logic [31:0] m = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (m_alive[r][c]) m[r*COLS+c] = 1'b1;
        return m;
    endfunction

    function automatic bit model_gfx(int sx, int sy);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (m_alive[r][c] && sx >= m_ox + c * PX && sx < m_ox + c * PX + SW &&
                    sy >= m_oy + r * PY && sy < m_oy + r * PY + SH) return 1'b1;
        return 1'b0;
    endfunction

    // ---------------- drivers ----------------
    task automatic step_cycle(input bit t, input bit kv, input int kr, input int kc);
        tick = t; kill_valid = kv; kill_row = 2'(kr); kill_col = 3'(kc);
        model_apply(t, kv, kr, kc);
        @(posedge clk); #1;
        tick = 1'b0; kill_valid = 1'b0;
    endtask

    task automatic do_reset();
        tick = 1'b0; kill_valid = 1'b0; rst_n = 1'b0;
        #2;
        model_reset();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        step_period = 16'd0;
        repeat (7) step_cycle(1, 0, 0, 0);
        step_cycle(0, 1, 1, 1);
        // asynchronous assertion mid-operation, checked before any clock edge
        @(negedge clk); #1; rst_n = 1'b0; #1;
        model_reset();
        n_tests++; if (origin_x !== 16'(IX)) begin n_fail++; $display("FAIL reset_origin_x: got %0d expected %0d", origin_x, IX); end
        n_tests++; if (origin_y !== 16'(IY)) begin n_fail++; $display("FAIL reset_origin_y: got %0d expected %0d", origin_y, IY); end
        n_tests++; if (alive_mask !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL reset_mask: got %h expected ffffffff", alive_mask); end
        n_tests++; if (alive_count !== 8'd32) begin n_fail++; $display("FAIL reset_count: got %0d expected 32", alive_count); end
        n_tests++; if (state_dbg !== RIGHT) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, RIGHT); end
        n_tests++; if (landed !== 1'b0 || cleared !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got landed=%b cleared=%b expected 0 0", landed, cleared); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        scan_x = 16'(IX + 4); scan_y = 16'(IY); #1;
        n_tests++; if (graphics !== 1'b0) begin n_fail++; $display("FAIL gfx_gap: got %b expected 0", graphics); end
        scan_x = 16'(IX + 3); scan_y = 16'(IY + 3); #1;
        n_tests++; if (graphics !== 1'b1) begin n_fail++; $display("FAIL gfx_corner: got %b expected 1", graphics); end
        scan_x = 16'(IX + 8); scan_y = 16'(IY + 24); #1;
        n_tests++; if (graphics !== 1'b1) begin n_fail++; $display("FAIL gfx_cell_3_1: got %b expected 1", graphics); end
        scan_x = 16'(IX - 1); scan_y = 16'(IY); #1;
        n_tests++; if (graphics !== 1'b0) begin n_fail++; $display("FAIL gfx_left_of_origin: got %b expected 0", graphics); end
    endtask

    task automatic test_pacing();
        do_reset();
        step_period = 16'd0;
        repeat (4) step_cycle(1, 0, 0, 0);
        n_tests++; if (origin_x !== 16'd20 || origin_y !== 16'd16) begin n_fail++; $display("FAIL pacing_4_ticks: got (%0d,%0d) expected (20,16)", origin_x, origin_y); end
        n_tests++; if (state_dbg !== RIGHT) begin n_fail++; $display("FAIL pacing_state: got %0d expected %0d", state_dbg, RIGHT); end
        step_period = 16'($urandom_range(1, 6));
        for (int i = 0; i < 80; i++) begin
            step_cycle(1'($urandom_range(0, 1)), 0, 0, 0);
            n_tests++; if (origin_x !== 16'(m_ox)) begin n_fail++; $display("FAIL pacing_origin_x: cycle %0d got %0d expected %0d", i, origin_x, m_ox); end
        end
    endtask

    task automatic test_bounce(input bit kill_col7);
        int max_x = 0;
        int cyc = 0;
        do_reset();
        step_period = 16'd0;
        if (kill_col7) begin
            for (int r = 0; r < ROWS; r++) step_cycle(0, 1, r, 7);
            n_tests++; if (alive_count !== 8'd28) begin n_fail++; $display("FAIL col7_count: got %0d expected 28", alive_count); end
            n_tests++; if (alive_mask !== 32'h7F7F_7F7F) begin n_fail++; $display("FAIL col7_mask: got %h expected 7f7f7f7f", alive_mask); end
        end
        while (!(m_oy == IY + DROPY && m_ox < 90) && cyc < 400) begin
            step_cycle(1, 0, 0, 0);
            cyc++;
            if (int'(origin_x) > max_x) max_x = int'(origin_x);
            n_tests++;
            if (origin_x !== 16'(m_ox) || origin_y !== 16'(m_oy) || state_dbg !== model_state()) begin
                n_fail++;
                $display("FAIL bounce_track: cycle %0d got x=%0d y=%0d st=%0d expected x=%0d y=%0d st=%0d",
                         cyc, origin_x, origin_y, state_dbg, m_ox, m_oy, model_state());
            end
        end
        n_tests++; if (cyc >= 400) begin n_fail++; $display("FAIL bounce_timeout: got %0d cycles expected < 400", cyc); end
        n_tests++;
        if (max_x != (kill_col7 ? 108 : 100)) begin
            n_fail++; $display("FAIL bounce_max_x: got %0d expected %0d", max_x, kill_col7 ? 108 : 100);
        end
        n_tests++; if (state_dbg !== LEFT || origin_y !== 16'd20) begin n_fail++; $display("FAIL bounce_after_drop: got st=%0d y=%0d expected st=%0d y=20", state_dbg, origin_y, LEFT); end
    endtask

    task automatic test_kills_clear();
        int order [31];
        do_reset();
        step_period = 16'd1;
        step_cycle(0, 1, 0, 0);
        step_cycle(1, 1, 0, 0);
        n_tests++; if (alive_count !== 8'd31 || alive_mask[0] !== 1'b0) begin n_fail++; $display("FAIL double_kill: got count=%0d bit0=%b expected 31 0", alive_count, alive_mask[0]); end
        for (int i = 0; i < 31; i++) order[i] = i + 1;
        for (int i = 30; i > 0; i--) begin
            int j = $urandom_range(0, i);
            int tmp = order[i];
            order[i] = order[j]; order[j] = tmp;
        end
        for (int i = 0; i < 31; i++) begin
            if (i == 30) begin
                n_tests++; if (cleared !== 1'b0) begin n_fail++; $display("FAIL clear_early: got %b expected 0", cleared); end
            end
            step_cycle(1'($urandom_range(0, 1)), 1, order[i] / COLS, order[i] % COLS);
            n_tests++;
            if (alive_count !== 8'(m_count) || alive_mask !== model_mask() || origin_x !== 16'(m_ox)) begin
                n_fail++; $display("FAIL kill_track: kill %0d got count=%0d mask=%h x=%0d expected count=%0d mask=%h x=%0d",
                                   i, alive_count, alive_mask, origin_x, m_count, model_mask(), m_ox);
            end
        end
        n_tests++; if (cleared !== 1'b1 || state_dbg !== HALT || alive_count !== 8'd0) begin n_fail++; $display("FAIL clear_edge: got cleared=%b st=%0d count=%0d expected 1 %0d 0", cleared, state_dbg, alive_count, HALT); end
        repeat (10) step_cycle(1, 0, 0, 0);
        n_tests++; if (origin_x !== 16'(m_ox) || origin_y !== 16'(m_oy) || landed !== 1'b0) begin n_fail++; $display("FAIL clear_frozen: got (%0d,%0d) landed=%b expected (%0d,%0d) 0", origin_x, origin_y, landed, m_ox, m_oy); end
    endtask

    task automatic test_landing();
        int cyc = 0;
        do_reset();
        step_period = 16'd0;
        while (!m_halt && cyc < 4000) begin
            step_cycle(1, 0, 0, 0);
            cyc++;
            n_tests++;
            if (origin_y !== 16'(m_oy) || landed !== m_landed) begin
                n_fail++; $display("FAIL land_track: cycle %0d got y=%0d landed=%b expected y=%0d landed=%b", cyc, origin_y, landed, m_oy, m_landed);
            end
        end
        n_tests++; if (cyc >= 4000) begin n_fail++; $display("FAIL land_timeout: got %0d cycles expected < 4000", cyc); end
        n_tests++; if (landed !== 1'b1 || state_dbg !== HALT || cleared !== 1'b0) begin n_fail++; $display("FAIL land_flags: got landed=%b st=%0d cleared=%b expected 1 %0d 0", landed, state_dbg, cleared, HALT); end
        n_tests++; if (origin_y !== 16'd84) begin n_fail++; $display("FAIL land_origin_y: got %0d expected 84", origin_y); end
        step_cycle(1, 1, 0, 0);
        step_cycle(1, 0, 0, 0);
        n_tests++; if (alive_count !== 8'd32 || origin_x !== 16'(m_ox) || origin_y !== 16'd84) begin n_fail++; $display("FAIL halt_frozen: got count=%0d x=%0d y=%0d expected 32 %0d 84", alive_count, origin_x, origin_y, m_ox); end
    endtask

    task automatic test_period_scaling();
        int last, interval;
        logic [15:0] prev;
        do_reset();
        step_period = 16'd8;
        for (int r = 0; r < 2; r++) for (int c = 0; c < COLS; c++) step_cycle(0, 1, r, c);
        last = -1; interval = 0; prev = origin_x;
        for (int i = 0; i < 45; i++) begin
            step_cycle(1, 0, 0, 0);
            n_tests++; if (origin_x !== 16'(m_ox)) begin n_fail++; $display("FAIL half_track: tick %0d got %0d expected %0d", i, origin_x, m_ox); end
            if (origin_x != prev) begin
                if (last >= 0) interval = i - last;
                last = i; prev = origin_x;
            end
        end
        n_tests++; if (interval != EXP_HALF) begin n_fail++; $display("FAIL half_interval: got %0d expected %0d", interval, EXP_HALF); end
        for (int c = 0; c < COLS; c++) step_cycle(0, 1, 2, c);
        last = -1; interval = 0; prev = origin_x;
        for (int i = 0; i < 30; i++) begin
            step_cycle(1, 0, 0, 0);
            if (origin_x != prev) begin
                if (last >= 0) interval = i - last;
                last = i; prev = origin_x;
            end
        end
        n_tests++; if (interval != EXP_QUARTER) begin n_fail++; $display("FAIL quarter_interval: got %0d expected %0d", interval, EXP_QUARTER); end
    endtask

    task automatic test_random();
        do_reset();
        step_period = 16'($urandom_range(0, 2));
        for (int i = 0; i < 1500; i++) begin
            step_cycle(1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0,
                       $urandom_range(0, ROWS - 1), $urandom_range(0, COLS - 1));
            n_tests++;
            if (origin_x !== 16'(m_ox) || origin_y !== 16'(m_oy) || alive_count !== 8'(m_count) ||
                alive_mask !== model_mask() || state_dbg !== model_state() ||
                landed !== m_landed || cleared !== m_cleared) begin
                n_fail++;
                $display("FAIL rand_state: cycle %0d got x=%0d y=%0d cnt=%0d mask=%h st=%0d l=%b c=%b expected x=%0d y=%0d cnt=%0d mask=%h st=%0d l=%b c=%b",
                         i, origin_x, origin_y, alive_count, alive_mask, state_dbg, landed, cleared,
                         m_ox, m_oy, m_count, model_mask(), model_state(), m_landed, m_cleared);
            end
            scan_x = 16'(m_ox + $urandom_range(0, 70) - 4);
            scan_y = 16'(m_oy + $urandom_range(0, 34) - 4);
            #1;
            n_tests++;
            if (graphics !== model_gfx(int'(scan_x), int'(scan_y))) begin
                n_fail++; $display("FAIL rand_gfx: scan (%0d,%0d) got %b expected %b", scan_x, scan_y, graphics, model_gfx(int'(scan_x), int'(scan_y)));
            end
        end
    endtask

    initial begin
        #12;
        test_reset();
        test_pacing();
        test_bounce(1'b0);
        test_bounce(1'b1);
        test_kills_clear();
        test_landing();
        test_period_scaling();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
